// File: rtl/dispatch_pkg.sv
// Types shared by the frame dispatcher, its bench and future stream controllers.
package dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      STREAM = 2'd2
   } state_e;

endpackage

// File: rtl/math_pkg.sv
// Shared arithmetic helpers used to size vectors from parameters.
package math_pkg;

   // Ceiling log2: number of bits needed to index 'value' items.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting channel after the last grant, wrapping.
module rr_arbiter
   import math_pkg::*;
#(
   parameter  int N_CHS = 8,
   localparam int CH_W  = log2(N_CHS)
) (
   input  logic [N_CHS-1:0] req_i,
   input  logic [CH_W-1:0]  last_i,
   output logic [CH_W-1:0]  grant_o,
   output logic             any_o
);

   always_comb begin
      logic [CH_W-1:0] idx;
      logic            found;
      // NOTE: every output gets a default before the loop, otherwise paths that skip an assignment infer latches.
      grant_o = '0;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < N_CHS; i++) begin
         idx = CH_W'((int'(last_i) + 1 + i) % N_CHS);
         if (!found && req_i[idx]) begin
            found   = 1'b1;
            grant_o = idx;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/frame_dispatcher.sv
// Dispatches framed input beats to a free decoder channel chosen round-robin,
// tracking per-channel busy flags and truncating frames at MAX_BEATS.
module frame_dispatcher
   import math_pkg::*;
   import dispatch_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int N_CHS      = 8,
   parameter  int MAX_BEATS  = 256,
   localparam int CH_W       = log2(N_CHS),
   localparam int CNT_W      = log2(MAX_BEATS) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_last,
   output logic                  o_ready,
   input  logic [N_CHS-1:0]      i_ch_done,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic [CH_W-1:0]       o_dev_sel,
   output logic [N_CHS-1:0]      o_busy,
   output logic                  o_trunc
);

   state_e                  state_q, state_d;
   logic [N_CHS-1:0]        busy_q, busy_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic [CH_W-1:0]         sel_q, sel_d;
   logic [CH_W-1:0]         last_q, last_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    trunc_q, trunc_d;
   logic [CH_W-1:0]         grant;
   logic                    grant_any;

   rr_arbiter #(.N_CHS(N_CHS)) u_arb (
      .req_i   (~busy_q),
      .last_i  (last_q),
      .grant_o (grant),
      .any_o   (grant_any)
   );

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q & ~i_ch_done;
      data_d  = data_q;
      valid_d = 1'b0;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      trunc_d = 1'b0;
      o_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (!(&busy_q)) state_d = SELECT;
         end
         SELECT: begin
            if (grant_any) begin
               sel_d   = grant;
               last_d  = grant;
               cnt_d   = '0;
               state_d = STREAM;
            end else begin
               state_d = IDLE;
            end
         end
         STREAM: begin
            o_ready = 1'b1;
            if (i_valid) begin
               data_d  = i_data;
               valid_d = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               // Setting after the done-clear lets a same-cycle set win.
               if (i_last || cnt_d == CNT_W'(MAX_BEATS)) begin
                  busy_d[sel_q] = 1'b1;
                  trunc_d       = !i_last;
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         busy_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sel_q   <= '0;
         last_q  <= CH_W'(N_CHS - 1);
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
         state_q <= state_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
      end
   end

   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_dev_sel = sel_q;
   assign o_busy    = busy_q;
   assign o_trunc   = trunc_q;

endmodule

// File: tb/tb_frame_dispatcher.sv
// Directed bench for frame_dispatcher: beats are scored against a queue of
// expected (data, channel) pairs; busy/ready/trunc are checked at key points.
module tb_frame_dispatcher;

   localparam int DW = 32;
   localparam int NC = 8;
   localparam int MB = 4;

   logic          i_clk;
   logic          i_rst;
   logic [DW-1:0] i_data;
   logic          i_valid;
   logic          i_last;
   logic          o_ready;
   logic [NC-1:0] i_ch_done;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic [2:0]    o_dev_sel;
   logic [NC-1:0] o_busy;
   logic          o_trunc;

   typedef struct {
      logic [DW-1:0] data;
      logic [2:0]    sel;
   } beat_t;

   beat_t q[$];
   int    total = 0;
   int    bad = 0;
   int    trunc_seen = 0;

   frame_dispatcher #(.DATA_WIDTH(DW), .N_CHS(NC), .MAX_BEATS(MB)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .i_last    (i_last),
      .o_ready   (o_ready),
      .i_ch_done (i_ch_done),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_dev_sel (o_dev_sel),
      .o_busy    (o_busy),
      .o_trunc   (o_trunc)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst     = 1'b1;
      i_valid   = 1'b0;
      i_last    = 1'b0;
      i_data    = '0;
      i_ch_done = '0;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   // Drive one beat, wait (bounded) for o_ready, score it, and hand it over.
   task automatic send_beat(input logic [DW-1:0] data, input logic last, input logic [2:0] sel);
      beat_t b;
      int    n;
      i_valid = 1'b1;
      i_data  = data;
      i_last  = last;
      n = 0;
      while (!o_ready && n < 50) begin
         tick();
         n++;
      end
      if (!o_ready) begin
         total++;
         bad++;
         $error("FAIL ready_timeout: observed=o_ready low for %0d cycles expected=high", n);
      end else begin
         b.data = data;
         b.sel  = sel;
         q.push_back(b);
      end
      tick();
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   always @(negedge i_clk) begin
      beat_t b;
      if (o_trunc === 1'b1) trunc_seen++;
      if (o_valid === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL spurious_beat: observed data=%0h sel=%0d expected=no beat", o_data, o_dev_sel);
         end else begin
            b = q.pop_front();
            check("beat_data", o_data, b.data);
            check("beat_sel", 32'(o_dev_sel), 32'(b.sel));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state.
      do_reset();
      check("rst_valid", 32'(o_valid), 0);
      check("rst_data", o_data, 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_sel", 32'(o_dev_sel), 0);
      check("rst_ready", 32'(o_ready), 0);
      check("rst_trunc", 32'(o_trunc), 0);

      // 4-beat frame; i_last coincides with the MAX_BEATS count, so no trunc.
      for (int k = 1; k <= 4; k++) send_beat(DW'(k), k == 4, 3'd0);
      check("f4_busy", 32'(o_busy), 32'h01);
      check("f4_trunc", 32'(o_trunc), 0);
      check("f4_sel", 32'(o_dev_sel), 0);

      // Nine single-beat frames from reset: grants 0..7, then a stall.
      do_reset();
      for (int k = 0; k < 8; k++) send_beat(DW'(32'h100 + k), 1'b1, 3'(k));
      check("all_busy", 32'(o_busy), 32'hFF);
      i_valid = 1'b1;
      i_data  = 32'h99;
      i_last  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("stall_ready", 32'(o_ready), 0);
      end

      // Free channel 5; the stalled frame must go there.
      i_ch_done = 8'h20;
      tick();
      i_ch_done = '0;
      check("done5_busy", 32'(o_busy), 32'hDF);
      send_beat(32'h99, 1'b1, 3'd5);
      check("ch5_busy", 32'(o_busy), 32'hFF);

      // Build busy=0x05 with last grant 0, then check round-robin order.
      do_reset();
      i_ch_done = 8'hFF;
      tick();
      i_ch_done = '0;
      check("idle_done_ignored", 32'(o_busy), 0);
      for (int k = 0; k < 3; k++) send_beat(DW'(32'h200 + k), 1'b1, 3'(k));
      i_ch_done = 8'h03;
      tick();
      i_ch_done = '0;
      for (int k = 3; k < 8; k++) send_beat(DW'(32'h200 + k), 1'b1, 3'(k));
      send_beat(32'h208, 1'b1, 3'd0);
      check("wrap_busy", 32'(o_busy), 32'hFD);
      i_ch_done = 8'hF8;
      tick();
      i_ch_done = '0;
      check("rr_busy", 32'(o_busy), 32'h05);
      send_beat(32'h300, 1'b1, 3'd1);
      send_beat(32'h301, 1'b1, 3'd3);
      check("rr_busy_after", 32'(o_busy), 32'h0F);

      // 6-beat frame truncated at 4; a same-cycle done on channel 0 loses to the set.
      do_reset();
      trunc_seen = 0;
      for (int k = 0; k < 3; k++) send_beat(DW'(32'h10 + k), 1'b0, 3'd0);
      i_ch_done = 8'h01;
      send_beat(32'h13, 1'b0, 3'd0);
      i_ch_done = '0;
      check("trunc_pulse", 32'(o_trunc), 1);
      check("trunc_busy", 32'(o_busy), 32'h01);
      send_beat(32'h14, 1'b0, 3'd1);
      send_beat(32'h15, 1'b1, 3'd1);
      tick();
      check("tail_busy", 32'(o_busy), 32'h03);
      check("trunc_once", 32'(trunc_seen), 1);

      // Reset on beat 2 of a frame on channel 1.
      do_reset();
      send_beat(32'h50, 1'b1, 3'd0);
      send_beat(32'h61, 1'b0, 3'd1);
      i_valid = 1'b1;
      i_data  = 32'h62;
      i_rst   = 1'b1;
      tick();
      check("mid_rst_valid", 32'(o_valid), 0);
      check("mid_rst_busy", 32'(o_busy), 0);
      i_rst   = 1'b0;
      i_valid = 1'b0;
      send_beat(32'h77, 1'b1, 3'd0);
      check("post_rst_busy", 32'(o_busy), 32'h01);

      tick();
      tick();
      check("queue_empty", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
